run_controller: RTL and testbench

- Synthesizable run/termination controller for the multi-core pipeline harness.
- Sequences core reset, counts run cycles, and watches per-core trap-at-MEM flags.
- Applies a drain window after the trap or timeout, then requests a memory dump through a req/ack handshake.
- Generalises the fixed single-core trap-then-wait-then-finish flow: any core count, any/all trap policy, timeout, programmable drain.

---
 rtl/run_ctrl_pkg.sv | 24 ++
 rtl/run_trap_tracker.sv | 98 +++++++++
 rtl/run_controller.sv | 168 ++++++++++++++++
 tb/tb_run_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and helpers for the run/termination controller.
//   run_state_t    - controller sequence IDLE -> HOLD_RST -> RUN -> DRAIN -> DUMP -> DONE
//   TRAP_MODE_ANY  - finish on any enabled core trap
//   TRAP_MODE_ALL  - finish once every enabled core has trapped
//   clog2_min1()   - index width for a vector of n entries, never less than 1
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HOLD_RST,
      RUN,
      DRAIN,
      DUMP,
      DONE
   } run_state_t;

   localparam int TRAP_MODE_ANY = 0;
   localparam int TRAP_MODE_ALL = 1;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/run_trap_tracker.sv
// run_trap_tracker: per-core trap bookkeeping for run_controller.
//   clk, reset     - clock, asynchronous active-low reset
//   clr            - start accepted: clear all sticky state
//   acc            - accumulate traps this cycle (RUN or DRAIN)
//   en             - latched core enable mask
//   trap           - per-core trap_mem flags
//   trap_seen      - sticky enabled-trap flags
//   first_trap_id  - lowest enabled core trapping in the first trap cycle
//   trap_done      - termination condition over trap_seen | (trap & en)
// Optional (RUN_CONTROLLER_TRAP_STAMP_EN):
//   cycle_count    - current run cycle count
//   trap_stamp     - per-core cycle_count captured at that core's first trap
module run_trap_tracker
   import run_ctrl_pkg::*;
#(
   parameter int NUM_CORES = 1,
   parameter int TRAP_MODE = 0
`ifdef RUN_CONTROLLER_TRAP_STAMP_EN
   ,
   parameter int CYCLE_W   = 32
`endif
)(
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                clr,
   input  logic                                acc,
   input  logic [NUM_CORES-1:0]                en,
   input  logic [NUM_CORES-1:0]                trap,
   output logic [NUM_CORES-1:0]                trap_seen,
   output logic [clog2_min1(NUM_CORES)-1:0]    first_trap_id,
   output logic                                trap_done
`ifdef RUN_CONTROLLER_TRAP_STAMP_EN
   ,
   input  logic [CYCLE_W-1:0]                  cycle_count,
   output logic [NUM_CORES*CYCLE_W-1:0]        trap_stamp
`endif
);

   localparam int ID_W = clog2_min1(NUM_CORES);

   logic [NUM_CORES-1:0] hit;
   logic [NUM_CORES-1:0] seen;

   assign hit  = trap & en;
   assign seen = trap_seen | hit;

   function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_CORES-1:0] v);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (v[i]) idx = ID_W'(i);
      end
      return idx;
   endfunction

   // An empty enable mask must never satisfy the all-trapped test.
   always_comb begin
      trap_done = 1'b0;
      if (TRAP_MODE == TRAP_MODE_ALL) begin
         trap_done = (en != '0) && ((seen & en) == en);
      end else begin
         trap_done = |seen;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trap_seen     <= '0;
         first_trap_id <= '0;
      end else if (clr) begin
         trap_seen     <= '0;
         first_trap_id <= '0;
      end else if (acc) begin
         trap_seen <= seen;
         // No enabled trap recorded yet means this is the first trap cycle.
         if ((trap_seen == '0) && (hit != '0)) begin
            first_trap_id <= lowest_idx(hit);
         end
      end
   end

`ifdef RUN_CONTROLLER_TRAP_STAMP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trap_stamp <= '0;
      end else if (clr) begin
         trap_stamp <= '0;
      end else if (acc) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (hit[i] && !trap_seen[i]) begin
               trap_stamp[i*CYCLE_W +: CYCLE_W] <= cycle_count;
            end
         end
      end
   end
`endif

endmodule

// File: rtl/run_controller.sv
// run_controller: run/termination controller for the multi-core pipeline harness.
// Holds the cores in reset, counts run cycles, ends the run on trap or timeout,
// waits a drain window and then requests a memory dump via req/ack.
//   clk, reset     - clock, asynchronous active-low reset
//   start          - start pulse, honoured only in IDLE or DONE
//   core_en        - core enable mask, sampled with start
//   trap           - per-core trap_mem flags
//   dump_ack       - dump-complete acknowledge, honoured only in DUMP
//   core_rst_n     - active-low core reset
//   running        - high in RUN
//   dump_req       - held high in DUMP until acknowledged
//   done           - high in DONE
//   timed_out      - sticky, run ended by timeout
//   trap_seen      - sticky per-core trap flags
//   first_trap_id  - lowest core trapping in the first trap cycle
//   cycle_count    - run cycles elapsed (RUN + DRAIN), saturating
// Optional macro RUN_CONTROLLER_TRAP_STAMP_EN adds trap_stamp
// (NUM_CORES slices of CYCLE_W, cycle_count at each core's first trap).
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int NUM_CORES      = 1,
   parameter int CYCLE_W        = 32,
   parameter int RESET_HOLD     = 2,
   parameter int DRAIN_CYCLES   = 10,
   parameter int TIMEOUT_CYCLES = 17500,
   parameter int TRAP_MODE      = 0
)(
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [NUM_CORES-1:0]             core_en,
   input  logic [NUM_CORES-1:0]             trap,
   input  logic                             dump_ack,
   output logic                             core_rst_n,
   output logic                             running,
   output logic                             dump_req,
   output logic                             done,
   output logic                             timed_out,
   output logic [NUM_CORES-1:0]             trap_seen,
   output logic [clog2_min1(NUM_CORES)-1:0] first_trap_id,
   output logic [CYCLE_W-1:0]               cycle_count
`ifdef RUN_CONTROLLER_TRAP_STAMP_EN
   ,
   output logic [NUM_CORES*CYCLE_W-1:0]     trap_stamp
`endif
);

   localparam int HOLD_W  = clog2_min1(RESET_HOLD);
   localparam int DRAIN_W = clog2_min1(DRAIN_CYCLES);

   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);
   // DRAIN_CYCLES of 0 still spends one cycle in DRAIN.
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
   localparam logic [CYCLE_W-1:0] TO_LAST    = CYCLE_W'(TIMEOUT_CYCLES - 1);
   localparam bit                 TO_ON      = (TIMEOUT_CYCLES != 0);

   run_state_t             state;
   logic [NUM_CORES-1:0]   en_latched;
   logic [HOLD_W-1:0]      hold_cnt;
   logic [DRAIN_W-1:0]     drain_cnt;
   logic                   accept;
   logic                   accum;
   logic                   trap_done;

   function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   assign accept = start && ((state == IDLE) || (state == DONE));
   assign accum  = (state == RUN) || (state == DRAIN);

   run_trap_tracker #(
      .NUM_CORES (NUM_CORES),
      .TRAP_MODE (TRAP_MODE)
`ifdef RUN_CONTROLLER_TRAP_STAMP_EN
      ,
      .CYCLE_W   (CYCLE_W)
`endif
   ) u_trk (
      .clk           (clk),
      .reset         (reset),
      .clr           (accept),
      .acc           (accum),
      .en            (en_latched),
      .trap          (trap),
      .trap_seen     (trap_seen),
      .first_trap_id (first_trap_id),
      .trap_done     (trap_done)
`ifdef RUN_CONTROLLER_TRAP_STAMP_EN
      ,
      .cycle_count   (cycle_count),
      .trap_stamp    (trap_stamp)
`endif
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         en_latched  <= '0;
         hold_cnt    <= '0;
         drain_cnt   <= '0;
         cycle_count <= '0;
         timed_out   <= 1'b0;
         core_rst_n  <= 1'b0;
         running     <= 1'b0;
         dump_req    <= 1'b0;
         done        <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  en_latched  <= core_en;
                  cycle_count <= '0;
                  timed_out   <= 1'b0;
                  hold_cnt    <= '0;
                  core_rst_n  <= 1'b0;
                  done        <= 1'b0;
                  state       <= HOLD_RST;
               end
            end
            HOLD_RST: begin
               if (hold_cnt == HOLD_LAST) begin
                  core_rst_n <= 1'b1;
                  running    <= 1'b1;
                  state      <= RUN;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            RUN: begin
               cycle_count <= sat_inc(cycle_count);
               // A trap in the timeout cycle takes priority and leaves timed_out clear.
               if (trap_done) begin
                  running   <= 1'b0;
                  drain_cnt <= '0;
                  state     <= DRAIN;
               end else if (TO_ON && (cycle_count == TO_LAST)) begin
                  timed_out <= 1'b1;
                  running   <= 1'b0;
                  drain_cnt <= '0;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               cycle_count <= sat_inc(cycle_count);
               if (drain_cnt == DRAIN_LAST) begin
                  dump_req <= 1'b1;
                  state    <= DUMP;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            DUMP: begin
               if (dump_ack) begin
                  dump_req <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed scoreboard bench for run_controller.
// u_any: 4 cores, any-trap, hold 2, drain 10, timeout 100, 16-bit counter.
// u_all: 4 cores, all-trap, hold 3, drain 0, no timeout, 8-bit counter.
// Build with RUN_CONTROLLER_TRAP_STAMP_EN to include the trap_stamp checks.
module tb_run_controller;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        a_start, a_ack;
   logic [3:0]  a_en, a_trap;
   logic        a_crst, a_run, a_dreq, a_done, a_to;
   logic [3:0]  a_seen;
   logic [1:0]  a_id;
   logic [15:0] a_cc;

   logic        b_start, b_ack;
   logic [3:0]  b_en, b_trap;
   logic        b_crst, b_run, b_dreq, b_done, b_to;
   logic [3:0]  b_seen;
   logic [1:0]  b_id;
   logic [7:0]  b_cc;

`ifdef RUN_CONTROLLER_TRAP_STAMP_EN
   logic [63:0] a_stamp;
   logic [31:0] b_stamp;
`endif

   run_controller #(
      .NUM_CORES(4), .CYCLE_W(16), .RESET_HOLD(2),
      .DRAIN_CYCLES(10), .TIMEOUT_CYCLES(100), .TRAP_MODE(0)
   ) u_any (
      .clk(clk), .reset(reset), .start(a_start), .core_en(a_en), .trap(a_trap),
      .dump_ack(a_ack), .core_rst_n(a_crst), .running(a_run), .dump_req(a_dreq),
      .done(a_done), .timed_out(a_to), .trap_seen(a_seen), .first_trap_id(a_id),
      .cycle_count(a_cc)
`ifdef RUN_CONTROLLER_TRAP_STAMP_EN
      ,
      .trap_stamp(a_stamp)
`endif
   );

   run_controller #(
      .NUM_CORES(4), .CYCLE_W(8), .RESET_HOLD(3),
      .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0), .TRAP_MODE(1)
   ) u_all (
      .clk(clk), .reset(reset), .start(b_start), .core_en(b_en), .trap(b_trap),
      .dump_ack(b_ack), .core_rst_n(b_crst), .running(b_run), .dump_req(b_dreq),
      .done(b_done), .timed_out(b_to), .trap_seen(b_seen), .first_trap_id(b_id),
      .cycle_count(b_cc)
`ifdef RUN_CONTROLLER_TRAP_STAMP_EN
      ,
      .trap_stamp(b_stamp)
`endif
   );

   // Observation mux: sel 0 watches u_any, sel 1 watches u_all.
   int          sel = 0;
   logic        o_crst, o_run, o_dreq, o_done, o_to;
   logic [3:0]  o_seen;
   logic [1:0]  o_id;
   logic [15:0] o_cc;

   always_comb begin
      o_crst = a_crst; o_run = a_run; o_dreq = a_dreq; o_done = a_done;
      o_to = a_to; o_seen = a_seen; o_id = a_id; o_cc = a_cc;
      if (sel == 1) begin
         o_crst = b_crst; o_run = b_run; o_dreq = b_dreq; o_done = b_done;
         o_to = b_to; o_seen = b_seen; o_id = b_id; o_cc = {8'd0, b_cc};
      end
   end

   typedef struct {
      string       tag;
      logic [15:0] cc;
      logic [1:0]  id;
      logic        to;
      logic [3:0]  seen;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   lat;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string tag, input int cc, input int id, input bit to, input int seen);
      exp_t e;
      e.tag  = tag;
      e.cc   = 16'(cc);
      e.id   = 2'(id);
      e.to   = to;
      e.seen = 4'(seen);
      sb.push_back(e);
   endtask

   task automatic pulse_start(input logic [3:0] en);
      if (sel == 0) begin a_en = en; a_start = 1'b1; end
      else          begin b_en = en; b_start = 1'b1; end
      tick();
      a_start = 1'b0;
      b_start = 1'b0;
   endtask

   task automatic pulse_trap(input logic [3:0] m);
      if (sel == 0) a_trap = m; else b_trap = m;
      tick();
      a_trap = 4'h0;
      b_trap = 4'h0;
   endtask

   task automatic pulse_ack();
      if (sel == 0) a_ack = 1'b1; else b_ack = 1'b1;
      tick();
      a_ack = 1'b0;
      b_ack = 1'b0;
   endtask

   task automatic wait_cc(input int n, input string tag);
      int k = 0;
      while ((o_cc != 16'(n)) && (k < 2000)) begin
         tick();
         k++;
      end
      check(tag, o_cc, n);
   endtask

   task automatic wait_dump(output int ticks);
      exp_t e;
      int k = 0;
      while (!o_dreq && (k < 500)) begin
         tick();
         k++;
      end
      ticks = k;
      check("dump_req_rise", o_dreq, 1);
      check("sb_pending", sb.size(), 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({e.tag, "_cc"},   o_cc,   e.cc);
         check({e.tag, "_id"},   o_id,   e.id);
         check({e.tag, "_to"},   o_to,   e.to);
         check({e.tag, "_seen"}, o_seen, e.seen);
      end
   endtask

   initial begin
      int k;
      a_start = 0; a_ack = 0; a_en = 0; a_trap = 0;
      b_start = 0; b_ack = 0; b_en = 0; b_trap = 0;
      #1 reset = 1'b0;
      #11;
      // Reset state
      sel = 0;
      check("rst_crst", o_crst, 0);
      check("rst_run",  o_run,  0);
      check("rst_dreq", o_dreq, 0);
      check("rst_done", o_done, 0);
      check("rst_to",   o_to,   0);
      check("rst_seen", o_seen, 0);
      check("rst_id",   o_id,   0);
      check("rst_cc",   o_cc,   0);
      sel = 1;
      check("rst_b_crst", o_crst, 0);
      check("rst_b_done", o_done, 0);
      #2 reset = 1'b1;
      tick();

      // A1: single enabled core, trap on run cycle 40
      sel = 0;
      pulse_start(4'b0001);
      check("A1_hold0_crst", o_crst, 0);
      check("A1_hold0_run",  o_run,  0);
      tick();
      check("A1_hold1_crst", o_crst, 0);
      tick();
      check("A1_run_crst", o_crst, 1);
      check("A1_run_run",  o_run,  1);
      check("A1_run_cc0",  o_cc,   0);
      wait_cc(10, "A1_reach10");
      a_start = 1'b1; a_ack = 1'b1;
      tick();
      a_start = 1'b0; a_ack = 1'b0;
      check("A1_start_ignored_cc", o_cc, 11);
      check("A1_start_ignored_run", o_run, 1);
      check("A1_ack_ignored", o_dreq, 0);
      wait_cc(40, "A1_reach40");
      push_exp("A1", 51, 0, 0, 4'b0001);
      pulse_trap(4'b0001);
      check("A1_drain_run", o_run, 0);
      check("A1_drain_cc",  o_cc,  41);
      wait_dump(lat);
      check("A1_dump_lat", lat + 1, 11);
      pulse_ack();
      check("A1_done",     o_done, 1);
      check("A1_dreq_low", o_dreq, 0);
      check("A1_done_crst", o_crst, 1);
      repeat (5) tick();
      check("A1_cc_frozen", o_cc, 51);

      // A2: timeout with no traps, restarted from DONE
      pulse_start(4'b1111);
      check("A2_clr_done", o_done, 0);
      check("A2_clr_seen", o_seen, 0);
      check("A2_clr_cc",   o_cc,   0);
      tick(); tick();
      push_exp("A2", 110, 0, 1, 4'b0000);
      k = 0;
      while (o_run && (k < 500)) begin tick(); k++; end
      check("A2_drain_cc", o_cc, 100);
      check("A2_timed_out", o_to, 1);
      wait_dump(lat);
      check("A2_dump_lat", lat, 10);
      pulse_ack();

      // A3: trap in the timeout cycle wins
      pulse_start(4'b1111);
      check("A3_clr_to", o_to, 0);
      tick(); tick();
      wait_cc(99, "A3_reach99");
      push_exp("A3", 110, 2, 0, 4'b0100);
      pulse_trap(4'b0100);
      check("A3_to_clear", o_to, 0);
      check("A3_drain_cc", o_cc, 100);
      wait_dump(lat);
      pulse_ack();

      // A4: async reset during DRAIN, then a fresh run
      pulse_start(4'b0011);
      tick(); tick();
      wait_cc(20, "A4_reach20");
      pulse_trap(4'b0010);
      tick(); tick();
      #2 reset = 1'b0;
      #1;
      check("A4_rst_crst", o_crst, 0);
      check("A4_rst_run",  o_run,  0);
      check("A4_rst_dreq", o_dreq, 0);
      check("A4_rst_seen", o_seen, 0);
      check("A4_rst_cc",   o_cc,   0);
      #1 reset = 1'b1;
      repeat (15) tick();
      check("A4_no_dump", o_dreq, 0);
      check("A4_idle_done", o_done, 0);
      pulse_start(4'b1010);
      tick(); tick();
      wait_cc(5, "A4_reach5");
      push_exp("A4", 16, 1, 0, 4'b1010);
      pulse_trap(4'b1111);
      wait_dump(lat);
      pulse_ack();
      check("A4_done", o_done, 1);

      // B1: all-trap mode, en 1011, drain 0, ack withheld
      sel = 1;
      pulse_start(4'b1011);
      check("B1_hold0_crst", o_crst, 0);
      tick();
      check("B1_hold1_crst", o_crst, 0);
      tick();
      check("B1_hold2_crst", o_crst, 0);
      tick();
      check("B1_run_crst", o_crst, 1);
      check("B1_run_run",  o_run,  1);
      wait_cc(4, "B1_reach4");
      pulse_trap(4'b1000);
      check("B1_after3_run", o_run, 1);
      wait_cc(8, "B1_reach8");
      pulse_trap(4'b0001);
      check("B1_after0_run", o_run, 1);
      wait_cc(12, "B1_reach12");
      pulse_trap(4'b0100);
      check("B1_after2_run",  o_run,  1);
      check("B1_after2_seen", o_seen, 4'b1001);
      wait_cc(15, "B1_reach15");
      push_exp("B1", 17, 3, 0, 4'b1011);
      pulse_trap(4'b0010);
      check("B1_drain_run", o_run, 0);
      check("B1_drain_dreq", o_dreq, 0);
      wait_dump(lat);
      check("B1_dump_lat", lat, 1);
      repeat (20) tick();
      check("B1_hold_dreq", o_dreq, 1);
      check("B1_hold_done", o_done, 0);
      check("B1_hold_cc",   o_cc,   17);
      pulse_ack();
      check("B1_done", o_done, 1);

      // BS: cores 2 and 0 trap at run cycles 7 and 19
      pulse_start(4'b0101);
      tick(); tick(); tick();
      wait_cc(7, "BS_reach7");
      push_exp("BS", 21, 2, 0, 4'b0101);
      pulse_trap(4'b0100);
      check("BS_after2_run", o_run, 1);
      wait_cc(19, "BS_reach19");
      pulse_trap(4'b0001);
      check("BS_drain_run", o_run, 0);
      wait_dump(lat);
`ifdef RUN_CONTROLLER_TRAP_STAMP_EN
      check("BS_stamp_c0", b_stamp[7:0],   19);
      check("BS_stamp_c1", b_stamp[15:8],  0);
      check("BS_stamp_c2", b_stamp[23:16], 7);
      check("BS_stamp_c3", b_stamp[31:24], 0);
`endif
      pulse_ack();

      // B2: empty enable mask, no timeout, toggling traps, counter saturation
      pulse_start(4'b0000);
`ifdef RUN_CONTROLLER_TRAP_STAMP_EN
      check("B2_stamp_clr", b_stamp, 0);
`endif
      check("B2_clr_seen", o_seen, 0);
      tick(); tick(); tick();
      for (int i = 0; i < 300; i++) begin
         b_trap = (i % 2 == 1) ? 4'hF : 4'h0;
         tick();
      end
      b_trap = 4'h0;
      check("B2_still_run", o_run,  1);
      check("B2_seen_zero", o_seen, 0);
      check("B2_cc_sat",    o_cc,   255);
      check("B2_no_dreq",   o_dreq, 0);
      #2 reset = 1'b0;
      #1;
      check("B2_rst_run", o_run, 0);
      check("B2_rst_cc",  o_cc,  0);
      #1 reset = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
